// File: rtl/multicycle_seq_pkg.sv
// rtl/multicycle_seq_pkg.sv - shared state encodings for the AlicePU multi-cycle sequencer
package multicycle_seq_pkg;

    localparam int SEQ_ST_LEN = 3;

    typedef enum logic [SEQ_ST_LEN-1:0] {
        SEQ_ST_IDLE   = 3'd0,
        SEQ_ST_FETCH  = 3'd1,
        SEQ_ST_DECODE = 3'd2,
        SEQ_ST_EXEC   = 3'd3,
        SEQ_ST_MEM    = 3'd4,
        SEQ_ST_WB     = 3'd5,
        SEQ_ST_ERR    = 3'd6
    } seq_state_t;

    // Where an instruction goes once it has retired.
    function automatic seq_state_t retire_target(input logic run);
        return run ? SEQ_ST_FETCH : SEQ_ST_IDLE;
    endfunction

endpackage

// File: rtl/multicycle_seq_watchdog.sv
// rtl/multicycle_seq_watchdog.sv - per-request wait counter with timeout compare
module multicycle_seq_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic waiting,
    output logic expired
);

    localparam int LIMIT_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0] LIMIT = LIMIT_I[TMO_W-1:0];

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (waiting) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires on the waiting cycle that would take the count to MEM_TIMEOUT;
    // a ready on that cycle deasserts waiting and so wins.
    assign expired = (MEM_TIMEOUT != 0) && waiting && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    input  logic                  dec_mem_read,
    input  logic                  dec_mem_write,
    input  logic                  dec_reg_write,
    output logic                  imem_req,
    output logic                  ir_load,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  pc_write,
    output logic                  rf_write,
    output logic                  busy,
    output logic                  mem_err,
    output logic [SEQ_ST_LEN-1:0] state,
    output logic [CNT_W-1:0]      retired
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [CNT_W-1:0] r_retired;
    logic             r_mem_err;
    logic             w_waiting;
    logic             w_expired;
    logic             w_mem_access;

    assign w_mem_access = dec_mem_read | dec_mem_write;
    assign w_waiting    = ((r_state == SEQ_ST_FETCH) && !imem_ready) ||
                          ((r_state == SEQ_ST_MEM)   && !dmem_ready);

    // Clearing whenever nothing is outstanding means each new request starts from zero.
    multicycle_seq_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!w_waiting),
        .waiting (w_waiting),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SEQ_ST_IDLE;
            r_retired <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (pc_write) begin
                r_retired <= r_retired + 1'b1;
            end
            if (w_next == SEQ_ST_ERR) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SEQ_ST_IDLE:   w_next = run ? SEQ_ST_FETCH : SEQ_ST_IDLE;
            SEQ_ST_FETCH: begin
                if (imem_ready)     w_next = SEQ_ST_DECODE;
                else if (w_expired) w_next = SEQ_ST_ERR;
            end
            SEQ_ST_DECODE: w_next = SEQ_ST_EXEC;
            SEQ_ST_EXEC: begin
                if (w_mem_access)       w_next = SEQ_ST_MEM;
                else if (dec_reg_write) w_next = SEQ_ST_WB;
                else                    w_next = retire_target(run);
            end
            SEQ_ST_MEM: begin
                // A write wins over a read when both decode bits are set.
                if (dmem_ready)     w_next = dec_mem_write ? retire_target(run) : SEQ_ST_WB;
                else if (w_expired) w_next = SEQ_ST_ERR;
            end
            SEQ_ST_WB:     w_next = retire_target(run);
            SEQ_ST_ERR:    w_next = SEQ_ST_ERR;
            default:       w_next = SEQ_ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_write = 1'b0;
        rf_write = 1'b0;
        case (r_state)
            SEQ_ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            SEQ_ST_EXEC: begin
                pc_write = !w_mem_access && !dec_reg_write;
            end
            SEQ_ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                pc_write = dmem_ready && dec_mem_write;
            end
            SEQ_ST_WB: begin
                rf_write = dec_reg_write;
                pc_write = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;
    assign mem_err = r_mem_err;
    assign busy    = (r_state != SEQ_ST_IDLE) && (r_state != SEQ_ST_ERR);

endmodule
